branch_pred_unit: RTL

Dynamic branch predictor and resolution checker that feeds the pipeline flush controller. It holds a direct-mapped table of 2-bit saturating counters with a branch target buffer, and predicts in decode from the PC looked up in fetch. It checks each resolved control-flow instruction in execute against the prediction carried down the pipe. It drives `branch_taken` (predicted-taken redirect in decode) and `branch_mispredicted` (wrong prediction found in execute), plus the redirect PC for fetch.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_sat_ctr_update.sv | 29 ++
 rtl/branch_pred_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor: default table geometry,
// 2-bit saturating counter encodings and the BTB entry layout.
// No ports (package).
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int IDX_BITS_DEF = 6;
    localparam int TAG_BITS_DEF = XLEN_DEF - IDX_BITS_DEF - 2;

    // Counter states: strong/weak not-taken, weak/strong taken.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                    valid;
        logic [TAG_BITS_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]     target;
    } btb_entry_t;

    // The upper counter bit is the taken/not-taken opinion.
    function automatic logic ctr_predicts_taken(input ctr_e c);
        return c[1];
    endfunction

endpackage

// File: rtl/bp_sat_ctr_update.sv
// -----------------------------------------------------------------------------
// bp_sat_ctr_update
// Pure combinational next-state for one 2-bit saturating counter.
//   ctr_i   : current counter value
//   taken_i : resolved branch direction
//   ctr_o   : counter value after training with taken_i
// -----------------------------------------------------------------------------
module bp_sat_ctr_update
    import bp_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) begin
                ctr_o = ctr_e'(ctr_i + 2'b01);
            end
        end else begin
            if (ctr_i != CTR_SNT) begin
                ctr_o = ctr_e'(ctr_i - 2'b01);
            end
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// -----------------------------------------------------------------------------
// branch_pred_unit
// Direct-mapped 2-bit counter table plus BTB. Looks up in fetch, predicts in
// decode (one cycle later), checks resolved control flow in execute and
// trains the tables.
//   clk, reset (async, active low)
//   f_pc, f_valid          : fetch lookup
//   d_stall                : hold decode registers
//   ex_*                   : resolved instruction and the prediction it carried
//   d_pred_taken/target    : decode prediction (carried down the pipe)
//   branch_taken           : predicted-taken redirect from decode
//   branch_mispredicted    : execute-stage correction
//   redirect_pc            : next fetch PC when either flag is set, else 0
// -----------------------------------------------------------------------------
module branch_pred_unit
    import bp_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int TAG_BITS = XLEN - IDX_BITS - 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] f_pc,
    input  logic            f_valid,
    input  logic            d_stall,
    input  logic            ex_valid,
    input  logic            ex_is_cf,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_actual_taken,
    input  logic [XLEN-1:0] ex_actual_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            d_pred_taken,
    output logic [XLEN-1:0] d_pred_target,
    output logic            branch_taken,
    output logic            branch_mispredicted,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int              ENTRIES = 1 << IDX_BITS;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Tables
    ctr_e       ctr_q [ENTRIES];
    btb_entry_t btb_q [ENTRIES];

    // Decode-stage registers
    logic            d_valid_q, d_valid_d;
    logic [XLEN-1:0] d_pc_q,    d_pc_d;
    ctr_e            d_ctr_q,   d_ctr_d;
    btb_entry_t      d_btb_q,   d_btb_d;

    logic [IDX_BITS-1:0] f_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0] ex_tag;
    ctr_e                ex_ctr_nxt;
    logic                cf_update;
    logic                alias_clear;
    logic                d_hit;
    logic                dir_diff;
    logic                tgt_diff;
    logic                mispredict;
    logic                pred_redirect;

    assign f_idx  = f_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_BITS+2];

    // ------------------------------------------------------------------
    // Lookup: capture the indexed entry; the table write on the same edge
    // is non-blocking, so a same-index update is seen only by the next
    // lookup.
    // ------------------------------------------------------------------
    always_comb begin
        d_valid_d = d_valid_q;
        d_pc_d    = d_pc_q;
        d_ctr_d   = d_ctr_q;
        d_btb_d   = d_btb_q;
        if (!d_stall) begin
            d_valid_d = f_valid;
            d_pc_d    = f_pc;
            d_ctr_d   = ctr_q[f_idx];
            d_btb_d   = btb_q[f_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid_q <= 1'b0;
            d_pc_q    <= '0;
            d_ctr_q   <= CTR_SNT;
            d_btb_q   <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_pc_q    <= d_pc_d;
            d_ctr_q   <= d_ctr_d;
            d_btb_q   <= d_btb_d;
        end
    end

    // ------------------------------------------------------------------
    // Training from execute
    // ------------------------------------------------------------------
    bp_sat_ctr_update u_ctr_update (
        .ctr_i   (ctr_q[ex_idx]),
        .taken_i (ex_actual_taken),
        .ctr_o   (ex_ctr_nxt)
    );

    assign cf_update = ex_valid & ex_is_cf;

    // A non-CF instruction that hit in the BTB: drop the entry only if it
    // really belongs to this PC, so an unrelated same-index branch survives.
    assign alias_clear = ex_valid & ~ex_is_cf & ex_pred_taken
                       & btb_q[ex_idx].valid
                       & (btb_q[ex_idx].tag == ex_tag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
                btb_q[i] <= '0;
            end
        end else begin
            if (cf_update) begin
                ctr_q[ex_idx] <= ex_ctr_nxt;
                if (ex_actual_taken) begin
                    btb_q[ex_idx].valid  <= 1'b1;
                    btb_q[ex_idx].tag    <= ex_tag;
                    btb_q[ex_idx].target <= ex_actual_target;
                end
            end else if (alias_clear) begin
                btb_q[ex_idx].valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode prediction
    // ------------------------------------------------------------------
    assign d_hit = d_valid_q & d_btb_q.valid
                 & (d_btb_q.tag == d_pc_q[XLEN-1:IDX_BITS+2]);

    assign d_pred_taken  = d_hit & ctr_predicts_taken(d_ctr_q);
    assign d_pred_target = d_pred_taken ? d_btb_q.target : (d_pc_q + PC_STEP);

    // ------------------------------------------------------------------
    // Execute check and redirect
    // ------------------------------------------------------------------
    assign dir_diff = ex_actual_taken ^ ex_pred_taken;
    assign tgt_diff = ex_actual_taken & ex_pred_taken
                    & (ex_actual_target != ex_pred_target);

    assign mispredict = ex_valid & (ex_is_cf ? (dir_diff | tgt_diff) : ex_pred_taken);

    // Execute correction always beats a younger decode redirect.
    assign pred_redirect = d_pred_taken & ~d_stall & ~mispredict;

    always_comb begin
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = (ex_is_cf & ex_actual_taken) ? ex_actual_target
                                                       : (ex_pc + PC_STEP);
        end else if (pred_redirect) begin
            redirect_pc = d_pred_target;
        end
    end

    assign branch_mispredicted = mispredict;
    assign branch_taken        = pred_redirect;

endmodule
